if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage and IF/ID pipeline register feeding the ctrl/decode stage. Holds the PC, issues word fetches over a valid/ready instruction-memory handshake, and presents `{pc, pc+4, instr, valid}` to ID. Consumes ctrl's one-hot `PcMuxSel`, `Stall` and `Branch` to redirect, freeze or bubble the front end, and absorbs variable imem latency with a one-entry skid buffer.

## Interface
- `RESET_PC`, 32'h0040_0000: PC value loaded on reset.
- `NOP`, 32'h0000_0000: instruction injected as a bubble (`sll $0,$0,0`).
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `pc_mux_sel`  in  4: one-hot from ctrl; [3] J/JAL target, [2] taken-branch target, [1] JR target, [0] sequential.
- `j_target`, `br_target`, `jr_target`  in  32 each: redirect targets computed in ID.
- `branch`  in  1: ctrl `Branch`; redirect request this cycle.
- `stall`  in  5: ctrl `Stall`; [0] hold PC, [1] hold IF/ID; [4:2] ignored.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch address (= PC).
- `imem_ready`  in  1: response valid; `imem_rdata` is sampled in the same cycle.
- `imem_rdata`  in  32: fetched word.
- `id_pc`, `id_pc4`  out  32 each: PC and PC+4 of the ID instruction.
- `id_instr`  out  32: instruction to ID.
- `id_valid`  out  1: `id_instr` is real (0 = bubble).

## Operation
- States: `S_REQ` (request outstanding), `S_HOLD` (word in skid buffer, ID frozen), `S_DROP` (discard stale in-flight response).
- `S_REQ`: `imem_req=1`, `imem_addr=pc`.
  - `imem_ready & ~stall[1] & ~redirect`: IF/ID <= `{pc, pc+4, rdata, 1}`; `pc <= pc+4`; stay.
  - `imem_ready & stall[1]`: skid <= rdata; go to `S_HOLD`.
  - `~imem_ready`: IF/ID keeps its value if `stall[1]`, else loads a bubble.
- `S_HOLD`: `imem_req=0`. When `stall[1]` falls: IF/ID <= skid entry; `pc <= pc+4`; go to `S_REQ`.
- Redirect = `branch & ~stall[0]`.
  - `pc <= target`, selected by priority [3]>[2]>[1]>[0]; a non-one-hot `pc_mux_sel` resolves by this priority.
  - Next IF/ID is a bubble (`NOP`, valid 0, pc fields 0).
  - The skid entry is invalidated.
  - From `S_REQ` without `imem_ready`: go to `S_DROP`. From `S_REQ` with ready, or from `S_HOLD`: go to `S_REQ`.
- `S_DROP`: `imem_req=0`. The next `imem_ready` is discarded; then go to `S_REQ` at the new PC.
- `stall[0]` outranks `branch`: the redirect is ignored and ctrl re-asserts it, because the branch is still held in ID.
- A PC increment only occurs when a fetched word is accepted into IF/ID.
- All PC arithmetic is modulo 2^32; `pc+4` wraps from 32'hFFFF_FFFC to 0.
- Targets are used unmodified. There is no alignment check and no delay slot.

## Timing
- Reset: `pc=RESET_PC`, state `S_REQ`, `id_valid=0`, `id_instr=NOP`, `id_pc=id_pc4=0`, skid empty.
- `imem_req=1` with `imem_addr=RESET_PC` in the first cycle after `rst` deasserts.
- Latency: the word is visible on `id_*` one cycle after its `imem_ready` cycle. Zero-wait imem gives 1 instruction/cycle.
- Redirect cost: one bubble with zero-wait imem. With a pending fetch, the cost is one bubble plus the remaining latency of the dropped fetch.
- Reset mid-fetch clears all state immediately. imem shares `rst`, so no stale response returns.
- `stall[1]` with an empty pipeline (`id_valid=0`) still holds the bubble.

## Structure
- Shared package `if_pkg`:
  - state enum (`S_REQ`, `S_HOLD`, `S_DROP`)
  - `NOP` and `RESET_PC` constants
  - `PcMuxSel` bit indices (`PCS_J=3`, `PCS_BR=2`, `PCS_JR=1`, `PCS_SEQ=0`)
  - `Stall` bit indices (`STL_PC=0`, `STL_IFID=1`)
- One sub-module, `pc_next_sel`: combinational priority selection of the next PC from `pc_mux_sel`, the three targets and `pc+4`.

## Test plan
- Zero-wait imem returns `32'h2008_0005` at `RESET_PC`: `id_instr=32'h2008_0005`, `id_pc=32'h0040_0000`, `id_pc4=32'h0040_0004`, `id_valid=1`; the next fetch address is `32'h0040_0004`.
- `stall=5'b00011` for 3 cycles in the same cycle as `imem_ready`: the word is held in skid with `imem_req=0`; `id_*` are unchanged. When the stall drops, the word appears in the next cycle and `pc` advances by 4 exactly once.
- `branch=1`, `pc_mux_sel=4'b0100`, `br_target=32'h0040_0040` with zero-wait imem: the next cycle has `id_valid=0` and `id_instr=0`; `imem_addr=32'h0040_0040`.
- `branch=1` on cycle 2 of a 4-cycle imem access: state goes to `S_DROP` and the returning word is never seen on `id_*`. The next request targets the redirect address.
- `branch=1` together with `stall[0]=1`: the PC is unchanged and there is no bubble. With `pc=32'hFFFF_FFFC`, a sequential fetch produces `id_pc4=0` and the next `imem_addr=0`.
- `rst` asserted while in `S_HOLD`: outputs return to reset values asynchronously, and `imem_addr=RESET_PC` after release.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states,
// IF/ID register layout, reset/bubble values and ctrl bit positions.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  localparam int PCS_J   = 3;
  localparam int PCS_BR  = 2;
  localparam int PCS_JR  = 1;
  localparam int PCS_SEQ = 0;

  localparam int STL_PC   = 0;
  localparam int STL_IFID = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // A bubble carries NOP with zeroed PC fields so ID never mistakes it for a real slot.
  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0};

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Priority selection of the redirect PC: J/JAL > taken branch > JR > sequential.
module pc_next_sel
  import if_pkg::*;
(
  input  logic [3:0]  pc_mux_sel,
  input  logic [31:0] j_target,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] pc4,
  output logic [31:0] next_pc
);

  logic unused_seq_bit;
  assign unused_seq_bit = pc_mux_sel[PCS_SEQ];

  always_comb begin
    // Sequential select and an all-zero select both fall through to pc+4.
    next_pc = pc4;
    if (pc_mux_sel[PCS_J]) begin
      next_pc = j_target;
    end else if (pc_mux_sel[PCS_BR]) begin
      next_pc = br_target;
    end else if (pc_mux_sel[PCS_JR]) begin
      next_pc = jr_target;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, one-entry skid buffer and
// redirect handling; feeds {pc, pc+4, instr, valid} to decode.
module if_stage
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  pc_mux_sel,
  input  logic [31:0] j_target,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_target,
  input  logic        branch,
  input  logic [4:0]  stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic [1:0]  dbg_state
);

  // imem handshake: imem_req/imem_addr stay stable while in S_REQ; a word is
  // transferred in any cycle where imem_ready is high, and imem_rdata is only
  // meaningful in that cycle. The request is dropped while a word sits in the
  // skid buffer or while a stale response is being discarded.

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4, target_pc;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;
  logic        redirect;
  logic        hold_ifid;

  logic [2:0] unused_stall_bits;
  assign unused_stall_bits = stall[4:2];

  assign pc4       = pc_q + 32'd4;
  assign redirect  = branch & ~stall[STL_PC];
  assign hold_ifid = stall[STL_IFID];

  pc_next_sel u_pc_next_sel (
    .pc_mux_sel (pc_mux_sel),
    .j_target   (j_target),
    .br_target  (br_target),
    .jr_target  (jr_target),
    .pc4        (pc4),
    .next_pc    (target_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d    = target_pc;
          ifid_d  = IFID_BUBBLE;
          state_d = imem_ready ? S_REQ : S_DROP;
        end else if (imem_ready && !hold_ifid) begin
          ifid_d = '{pc: pc_q, pc4: pc4, instr: imem_rdata, valid: 1'b1};
          pc_d   = pc4;
        end else if (imem_ready) begin
          skid_d     = imem_rdata;
          skid_vld_d = 1'b1;
          state_d    = S_HOLD;
        end else if (!hold_ifid) begin
          ifid_d = IFID_BUBBLE;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d       = target_pc;
          ifid_d     = IFID_BUBBLE;
          skid_vld_d = 1'b0;
          state_d    = S_REQ;
        end else if (!hold_ifid) begin
          ifid_d     = skid_vld_q ? '{pc: pc_q, pc4: pc4, instr: skid_q, valid: 1'b1}
                                  : IFID_BUBBLE;
          pc_d       = pc4;
          skid_vld_d = 1'b0;
          state_d    = S_REQ;
        end
      end

      S_DROP: begin
        // The in-flight word belongs to the old PC; a further redirect only
        // retargets the PC, the pending response must still be swallowed.
        if (redirect) begin
          pc_d   = target_pc;
          ifid_d = IFID_BUBBLE;
        end else if (!hold_ifid) begin
          ifid_d = IFID_BUBBLE;
        end
        if (imem_ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      ifid_q     <= IFID_BUBBLE;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign id_pc     = ifid_q.pc;
  assign id_pc4    = ifid_q.pc4;
  assign id_instr  = ifid_q.instr;
  assign id_valid  = ifid_q.valid;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, skid hold, redirects,
// dropped fetch, stall-vs-branch priority, PC wrap and async reset.
module tb_if_stage;
  import if_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  pc_mux_sel;
  logic [31:0] j_target, br_target, jr_target;
  logic        branch;
  logic [4:0]  stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc, id_pc4, id_instr;
  logic        id_valid;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc_mux_sel (pc_mux_sel),
    .j_target   (j_target),
    .br_target  (br_target),
    .jr_target  (jr_target),
    .branch     (branch),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_instr   (id_instr),
    .id_valid   (id_valid),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic imem_drive(input logic rdy, input logic [31:0] data);
    imem_ready = rdy;
    imem_rdata = data;
  endtask

  task automatic ctrl_drive(input logic br, input logic [3:0] sel, input logic [4:0] stl);
    branch     = br;
    pc_mux_sel = sel;
    stall      = stl;
  endtask

  initial begin
    rst = 1'b1;
    j_target = '0; br_target = '0; jr_target = '0;
    ctrl_drive(1'b0, 4'b0001, 5'b00000);
    imem_drive(1'b0, '0);
    repeat (3) step();

    check("rst_valid", id_valid, 1'b0);
    check("rst_instr", id_instr, NOP);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc4", id_pc4, 32'h0);
    check("rst_state", dbg_state, S_REQ);

    rst = 1'b0;
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0040_0000);

    // empty pipeline with IF/ID stall keeps the bubble and the fetch pending
    ctrl_drive(1'b0, 4'b0001, 5'b00010);
    step();
    check("empty_stall_valid", id_valid, 1'b0);
    check("empty_stall_addr", imem_addr, 32'h0040_0000);
    ctrl_drive(1'b0, 4'b0001, 5'b00000);

    // zero-wait fetch of the first word
    imem_drive(1'b1, 32'h2008_0005);
    step();
    check("w0_instr", id_instr, 32'h2008_0005);
    check("w0_pc", id_pc, 32'h0040_0000);
    check("w0_pc4", id_pc4, 32'h0040_0004);
    check("w0_valid", id_valid, 1'b1);
    check("w0_next_addr", imem_addr, 32'h0040_0004);

    // back-to-back stream, one word per cycle
    for (int i = 1; i <= 3; i++) begin
      imem_drive(1'b1, 32'h2400_0000 + 32'(i));
      exp_q.push_back(32'h2400_0000 + 32'(i));
      step();
      check("stream_instr", id_instr, exp_q.pop_front());
      check("stream_pc", id_pc, 32'h0040_0000 + 32'(4 * i));
    end
    check("stream_addr", imem_addr, 32'h0040_0010);

    // word arrives together with a full stall: parked in the skid buffer
    imem_drive(1'b1, 32'hCAFE_0001);
    ctrl_drive(1'b0, 4'b0001, 5'b00011);
    step();
    check("skid_state", dbg_state, S_HOLD);
    check("skid_req", imem_req, 1'b0);
    check("skid_id_instr", id_instr, 32'h2400_0003);
    imem_drive(1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold_req", imem_req, 1'b0);
      check("hold_id_pc", id_pc, 32'h0040_000C);
      check("hold_id_instr", id_instr, 32'h2400_0003);
    end
    ctrl_drive(1'b0, 4'b0001, 5'b00000);
    step();
    check("unskid_instr", id_instr, 32'hCAFE_0001);
    check("unskid_pc", id_pc, 32'h0040_0010);
    check("unskid_pc4", id_pc4, 32'h0040_0014);
    check("unskid_valid", id_valid, 1'b1);
    check("unskid_addr", imem_addr, 32'h0040_0014);
    step();
    check("no_word_bubble", id_valid, 1'b0);
    check("pc_once", imem_addr, 32'h0040_0014);

    // taken branch with zero-wait imem: one bubble, fetch from target
    br_target = 32'h0040_0040;
    imem_drive(1'b1, 32'hDEAD_0000);
    ctrl_drive(1'b1, 4'b0100, 5'b00000);
    step();
    check("br_valid", id_valid, 1'b0);
    check("br_instr", id_instr, 32'h0);
    check("br_pc", id_pc, 32'h0);
    check("br_addr", imem_addr, 32'h0040_0040);
    check("br_state", dbg_state, S_REQ);

    // redirect in cycle 2 of a 4-cycle access; non-one-hot select, J wins
    ctrl_drive(1'b0, 4'b0001, 5'b00000);
    imem_drive(1'b0, 32'h0);
    step();
    j_target = 32'h0050_0000;
    ctrl_drive(1'b1, 4'b1100, 5'b00000);
    step();
    check("drop_state", dbg_state, S_DROP);
    check("drop_req", imem_req, 1'b0);
    check("drop_addr", imem_addr, 32'h0050_0000);
    ctrl_drive(1'b0, 4'b0001, 5'b00000);
    step();
    check("drop_wait_state", dbg_state, S_DROP);
    imem_drive(1'b1, 32'hBAD0_BAD0);
    step();
    check("drop_done_state", dbg_state, S_REQ);
    check("drop_word_hidden", id_valid, 1'b0);
    check("drop_word_instr", id_instr, 32'h0);
    check("drop_next_addr", imem_addr, 32'h0050_0000);
    imem_drive(1'b1, 32'h1111_0000);
    step();
    check("tgt_instr", id_instr, 32'h1111_0000);
    check("tgt_pc", id_pc, 32'h0050_0000);

    // stall[0] outranks branch: no redirect, IF/ID held (no bubble)
    br_target = 32'h0060_0000;
    imem_drive(1'b0, 32'h0);
    ctrl_drive(1'b1, 4'b0100, 5'b00011);
    step();
    check("stl_br_addr", imem_addr, 32'h0050_0004);
    check("stl_br_valid", id_valid, 1'b1);
    check("stl_br_instr", id_instr, 32'h1111_0000);
    check("stl_br_state", dbg_state, S_REQ);

    // jump to the top of the address space, then fetch across the wrap
    j_target = 32'hFFFF_FFFC;
    imem_drive(1'b1, 32'h9999_9999);
    ctrl_drive(1'b1, 4'b1000, 5'b00000);
    step();
    check("wrap_tgt_addr", imem_addr, 32'hFFFF_FFFC);
    ctrl_drive(1'b0, 4'b0001, 5'b00000);
    imem_drive(1'b1, 32'h3333_0000);
    step();
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // asynchronous reset while a word sits in the skid buffer
    imem_drive(1'b1, 32'h4444_0000);
    ctrl_drive(1'b0, 4'b0001, 5'b00011);
    step();
    check("pre_rst_state", dbg_state, S_HOLD);
    imem_drive(1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", dbg_state, S_REQ);
    check("async_rst_valid", id_valid, 1'b0);
    check("async_rst_instr", id_instr, NOP);
    check("async_rst_pc", id_pc, 32'h0);
    step();
    rst = 1'b0;
    ctrl_drive(1'b0, 4'b0001, 5'b00000);
    #1;
    check("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, RESET_PC);
    step();
    check("post_rst_hold_addr", imem_addr, RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
